soundrive_fifo: RTL and testbench



---
 rtl/soundrive_fifo_if.sv | 31 +++
 rtl/soundrive_fifo.sv | 119 +++++++++++
 tb/tb_soundrive_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/soundrive_fifo_if.sv
// CPU I/O bus side and audio output side of the buffered Soundrive DAC.
// The bus master drives the I/O strobes, mode and sample tick; the DAC returns samples, mix and flags.
interface soundrive_fifo_if;
  logic       cs;
  logic [7:0] a;
  logic [7:0] di;
  logic       wr_n;
  logic       iorq_n;
  logic       dos;
  logic       mode;
  logic       tick;
  logic [7:0] outa;
  logic [7:0] outb;
  logic [7:0] outc;
  logic [7:0] outd;
  logic [8:0] left;
  logic [8:0] right;
  logic [3:0] full;
  logic [3:0] ovf;
  logic [3:0] unf;

  modport master (
    output cs, a, di, wr_n, iorq_n, dos, mode, tick,
    input  outa, outb, outc, outd, left, right, full, ovf, unf
  );

  modport slave (
    input  cs, a, di, wr_n, iorq_n, dos, mode, tick,
    output outa, outb, outc, outd, left, right, full, ovf, unf
  );
endinterface

// File: rtl/soundrive_fifo.sv
// Four-channel Soundrive/Covox DAC with per-channel sample FIFOs paced by an external tick.
// Channels A,B mix to left and C,D to right; index 0..3 maps to A..D throughout.
module soundrive_fifo #(
  parameter int         DEPTH   = 8,
  parameter logic [7:0] PORT_A  = 8'h0F,
  parameter logic [7:0] PORT_B  = 8'h1F,
  parameter logic [7:0] PORT_C  = 8'h4F,
  parameter logic [7:0] PORT_D  = 8'h5F,
  parameter logic [7:0] PORT_BD = 8'hFB
) (
  input  logic             clk,
  input  logic             reset,
  soundrive_fifo_if.slave  bus
);
  localparam int             PW       = $clog2(DEPTH);
  localparam int             LW       = PW + 1;
  localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

  logic          clear;
  logic          io_wr;
  logic          wr_q;
  logic          push;
  logic          mode_q;
  logic          mode_chg;
  logic          buffered;
  logic [3:0]    hit;
  logic [3:0]    pop;
  logic [3:0]    wr_req;
  logic [3:0]    accept;
  logic [3:0]    full_w;

  logic [7:0]    mem    [4][DEPTH];
  logic [PW-1:0] rd_ptr [4];
  logic [PW-1:0] wr_ptr [4];
  logic [LW-1:0] level  [4];
  logic [7:0]    out_q  [4];
  logic [3:0]    ovf_q;
  logic [3:0]    unf_q;
  logic [8:0]    left_q;
  logic [8:0]    right_q;

  assign clear    = reset | ~bus.cs;
  assign io_wr    = ~bus.iorq_n & ~bus.wr_n & ~bus.dos;
  // Rising edge of the decoded strobe: one push per I/O cycle regardless of its length.
  assign push     = io_wr & ~wr_q;
  assign mode_chg = bus.mode ^ mode_q;
  assign buffered = bus.mode & ~mode_chg;

  assign hit[0] = (bus.a == PORT_A);
  assign hit[1] = (bus.a == PORT_B) | (bus.a == PORT_BD);
  assign hit[2] = (bus.a == PORT_C);
  assign hit[3] = (bus.a == PORT_D) | (bus.a == PORT_BD);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the new byte.
  always_comb begin
    pop    = '0;
    wr_req = '0;
    accept = '0;
    full_w = '0;
    for (int k = 0; k < 4; k++) begin
      pop[k]    = buffered & bus.tick & (level[k] != '0);
      wr_req[k] = buffered & push & hit[k];
      accept[k] = wr_req[k] & ((level[k] != LVL_FULL) | pop[k]);
      full_w[k] = (level[k] == LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    if (clear) begin
      wr_q    <= 1'b0;
      ovf_q   <= '0;
      unf_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      for (int k = 0; k < 4; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        level[k]  <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      wr_q <= io_wr;
      for (int k = 0; k < 4; k++) begin
        if (mode_chg) begin
          rd_ptr[k] <= '0;
          wr_ptr[k] <= '0;
          level[k]  <= '0;
        end else begin
          if (pop[k]) begin
            out_q[k]  <= mem[k][rd_ptr[k]];
            rd_ptr[k] <= rd_ptr[k] + 1'b1;
          end
          if (accept[k]) begin
            mem[k][wr_ptr[k]] <= bus.di;
            wr_ptr[k]         <= wr_ptr[k] + 1'b1;
          end
          level[k] <= level[k] + LW'(accept[k]) - LW'(pop[k]);
          if (wr_req[k] & ~accept[k]) ovf_q[k] <= 1'b1;
          // An empty FIFO never bypasses: the out register holds even if a byte arrives now.
          if (buffered & bus.tick & (level[k] == '0)) unf_q[k] <= 1'b1;
        end
        if (~bus.mode & push & hit[k]) out_q[k] <= bus.di;
      end
      left_q  <= {1'b0, out_q[0]} + {1'b0, out_q[1]};
      right_q <= {1'b0, out_q[2]} + {1'b0, out_q[3]};
    end
  end

  assign bus.outa  = out_q[0];
  assign bus.outb  = out_q[1];
  assign bus.outc  = out_q[2];
  assign bus.outd  = out_q[3];
  assign bus.left  = left_q;
  assign bus.right = right_q;
  assign bus.full  = full_w;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_soundrive_fifo.sv
// Directed bench for soundrive_fifo: a vector table for the steady-state behaviour,
// followed by hand-written sequences for strobe timing, overflow, collisions and clear.
module tb_soundrive_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  soundrive_fifo_if bus ();

  soundrive_fifo #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;       // 0 = I/O write, 1 = sample tick
    logic [7:0] a;
    logic [7:0] di;
    logic       mode;
    logic       dos;
    logic [31:0] exp_out;   // {outd, outc, outb, outa}
    logic [8:0] exp_left;
    logic [8:0] exp_right;
    logic [3:0] exp_full;
    logic [3:0] exp_ovf;
    logic [3:0] exp_unf;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                          input int hold, input logic with_tick);
    bus.a      = addr;
    bus.di     = data;
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    bus.tick   = with_tick;
    step();
    bus.tick   = 1'b0;
    for (int i = 1; i < hold; i++) step();
    bus.iorq_n = 1'b1;
    bus.wr_n   = 1'b1;
    step();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic do_clear();
    bus.cs = 1'b0;
    step();
    bus.cs = 1'b1;
  endtask

  function automatic logic [31:0] outs();
    return {bus.outd, bus.outc, bus.outb, bus.outa};
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.cs     = 1'b1;
    bus.a      = 8'h00;
    bus.di     = 8'h00;
    bus.wr_n   = 1'b1;
    bus.iorq_n = 1'b1;
    bus.dos    = 1'b0;
    bus.mode   = 1'b0;
    bus.tick   = 1'b0;

    //             kind a      di     m     dos   outs {d,c,b,a}  left    right   full ovf  unf
    tbl[0]  = '{0, 8'hFB, 8'h40, 1'b0, 1'b0, 32'h40_00_40_00, 9'h040, 9'h040, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{0, 8'h0F, 8'h80, 1'b0, 1'b0, 32'h40_00_40_80, 9'h0C0, 9'h040, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{0, 8'h2F, 8'h55, 1'b0, 1'b0, 32'h40_00_40_80, 9'h0C0, 9'h040, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{0, 8'h4F, 8'h11, 1'b0, 1'b1, 32'h40_00_40_80, 9'h0C0, 9'h040, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{0, 8'h4F, 8'h22, 1'b0, 1'b0, 32'h40_22_40_80, 9'h0C0, 9'h062, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{0, 8'h5F, 8'h33, 1'b0, 1'b0, 32'h33_22_40_80, 9'h0C0, 9'h055, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{0, 8'h4F, 8'h01, 1'b1, 1'b0, 32'h33_22_40_80, 9'h0C0, 9'h055, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{0, 8'h4F, 8'h02, 1'b1, 1'b0, 32'h33_22_40_80, 9'h0C0, 9'h055, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{0, 8'h4F, 8'h03, 1'b1, 1'b0, 32'h33_22_40_80, 9'h0C0, 9'h055, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 32'h33_01_40_80, 9'h0C0, 9'h034, 4'h0, 4'h0, 4'hB};
    tbl[10] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 32'h33_02_40_80, 9'h0C0, 9'h035, 4'h0, 4'h0, 4'hB};
    tbl[11] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 32'h33_03_40_80, 9'h0C0, 9'h036, 4'h0, 4'h0, 4'hB};
    tbl[12] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 32'h33_03_40_80, 9'h0C0, 9'h036, 4'h0, 4'h0, 4'hF};

    step();
    step();
    check("reset_outs",  outs(),           32'h0);
    check("reset_left",  32'(bus.left),    32'h0);
    check("reset_right", 32'(bus.right),   32'h0);
    check("reset_flags", {20'h0, bus.full, bus.ovf, bus.unf}, 32'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      bus.mode = tbl[i].mode;
      step();
      bus.dos = tbl[i].dos;
      if (tbl[i].kind == 0) io_write(tbl[i].a, tbl[i].di, 1, 1'b0);
      else                  do_tick();
      bus.dos = 1'b0;
      step();
      step();
      check($sformatf("vec%0d_outs", i),  outs(),         tbl[i].exp_out);
      check($sformatf("vec%0d_left", i),  32'(bus.left),  32'(tbl[i].exp_left));
      check($sformatf("vec%0d_right", i), 32'(bus.right), 32'(tbl[i].exp_right));
      check($sformatf("vec%0d_full", i),  32'(bus.full),  32'(tbl[i].exp_full));
      check($sformatf("vec%0d_ovf", i),   32'(bus.ovf),   32'(tbl[i].exp_ovf));
      check($sformatf("vec%0d_unf", i),   32'(bus.unf),   32'(tbl[i].exp_unf));
    end

    // Overflow on channel A, then drain in order.
    do_clear();
    for (int i = 0; i < 9; i++) begin
      io_write(8'h0F, 8'h10 + 8'(i), 1, 1'b0);
      if (i == 6) check("ovf_full_after7", 32'(bus.full[0]), 32'h0);
      if (i == 7) begin
        check("ovf_full_after8", 32'(bus.full[0]), 32'h1);
        check("ovf_flag_after8", 32'(bus.ovf[0]),  32'h0);
      end
      if (i == 8) begin
        check("ovf_flag_after9", 32'(bus.ovf[0]),  32'h1);
        check("ovf_full_after9", 32'(bus.full[0]), 32'h1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check($sformatf("ovf_drain%0d", i), 32'(bus.outa), 32'h10 + 32'(i));
    end
    check("ovf_drained_full", 32'(bus.full[0]), 32'h0);
    check("ovf_sticky",       32'(bus.ovf[0]),  32'h1);
    check("ovf_no_unf_a",     32'(bus.unf[0]),  32'h0);

    // Push and tick together on a full channel B.
    do_clear();
    for (int i = 0; i < 8; i++) io_write(8'h1F, 8'h20 + 8'(i), 1, 1'b0);
    check("coll_prefull", 32'(bus.full[1]), 32'h1);
    io_write(8'h1F, 8'h28, 1, 1'b1);
    check("coll_full", 32'(bus.full[1]), 32'h1);
    check("coll_ovf",  32'(bus.ovf[1]),  32'h0);
    check("coll_outb", 32'(bus.outb),    32'h20);
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check($sformatf("coll_drain%0d", i), 32'(bus.outb), 32'h21 + 32'(i));
    end
    check("coll_empty", 32'(bus.full[1]), 32'h0);

    // Push and tick together on an empty channel C: no bypass.
    do_clear();
    io_write(8'h4F, 8'h77, 1, 1'b1);
    check("empty_coll_outc", 32'(bus.outc),   32'h0);
    check("empty_coll_unf",  32'(bus.unf[2]), 32'h1);
    do_tick();
    check("empty_coll_pop",  32'(bus.outc),   32'h77);

    // Dropping cs for one clk clears everything.
    io_write(8'h0F, 8'h99, 1, 1'b0);
    step();
    do_clear();
    check("clear_outs",  outs(),         32'h0);
    check("clear_left",  32'(bus.left),  32'h0);
    check("clear_right", 32'(bus.right), 32'h0);
    check("clear_flags", {20'h0, bus.full, bus.ovf, bus.unf}, 32'h0);

    // Direct-mode latency with a strobe held three clks.
    bus.mode = 1'b0;
    step();
    bus.a      = 8'h0F;
    bus.di     = 8'h80;
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    step();
    check("direct_outa_e1", 32'(bus.outa), 32'h80);
    check("direct_left_e1", 32'(bus.left), 32'h0);
    step();
    check("direct_left_e2", 32'(bus.left), 32'h080);
    step();
    bus.iorq_n = 1'b1;
    bus.wr_n   = 1'b1;
    step();
    check("direct_outa_end", 32'(bus.outa), 32'h80);
    check("direct_fifo_idle", 32'(bus.full), 32'h0);

    // A long strobe in buffered mode pushes exactly one byte.
    bus.mode = 1'b1;
    step();
    do_clear();
    io_write(8'h0F, 8'h5A, 3, 1'b0);
    do_tick();
    check("once_outa",  32'(bus.outa),   32'h5A);
    check("once_unf0",  32'(bus.unf[0]), 32'h0);
    do_tick();
    check("once_unf1",  32'(bus.unf[0]), 32'h1);
    check("once_hold",  32'(bus.outa),   32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
